// File: rtl/demux1x2_buf_if.sv
// Handshake bundle for demux1x2_buf: one input stream, two buffered output channels.
// count0/count1 exist only when DEMUX_COUNT_EN is defined.
interface demux1x2_buf_if #(
  parameter int size = 8,
  parameter int cntW = 8
);
  logic                flush;
  logic                sel;
  logic                inValid;
  logic [size-1:0]     inputVal;
  logic                inReady;
  logic [1:0]          outValid;
  logic [1:0]          outReady;
  logic [2*size-1:0]   y;
`ifdef DEMUX_COUNT_EN
  logic [cntW-1:0]     count0;
  logic [cntW-1:0]     count1;

  modport slave (
    input  flush, sel, inValid, inputVal, outReady,
    output inReady, outValid, y, count0, count1
  );

  modport master (
    output flush, sel, inValid, inputVal, outReady,
    input  inReady, outValid, y, count0, count1
  );
`else
  modport slave (
    input  flush, sel, inValid, inputVal, outReady,
    output inReady, outValid, y
  );

  modport master (
    output flush, sel, inValid, inputVal, outReady,
    input  inReady, outValid, y
  );
`endif

  if (size < 1 || cntW < 1) begin : g_param_check
    $error("demux1x2_buf_if: size and cntW must be at least 1");
  end
endinterface

// File: rtl/demux1x2_buf.sv
// 1:2 demultiplexer with a one-entry valid/ready register per output channel.
// Optional per-channel pop counters are enabled by defining DEMUX_COUNT_EN.
module demux1x2_buf #(
  parameter int size = 8,
  parameter int cntW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  demux1x2_buf_if.slave bus
);

  logic [1:0] valid_vec;
  logic [1:0] pop;
  logic [1:0] push;
  logic       in_ready;

  // Ready looks only at the selected channel, so a stalled consumer never
  // blocks traffic headed for the other one.
  always_comb begin
    in_ready = ~bus.flush & (~valid_vec[bus.sel] | bus.outReady[bus.sel]);
  end

  assign bus.inReady = in_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic            valid_q;
      logic            valid_d;
      logic [size-1:0] data_q;
      logic [size-1:0] data_d;

      assign pop[gi]  = valid_q & bus.outReady[gi];
      assign push[gi] = bus.inValid & in_ready & (bus.sel == 1'(gi));

      // A push in the same cycle as a pop replaces the word without a bubble;
      // flush drops the valid but leaves the data register alone.
      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (bus.flush) begin
          valid_d = 1'b0;
        end else begin
          valid_d = push[gi] | (valid_q & ~pop[gi]);
        end
        if (push[gi]) begin
          data_d = bus.inputVal;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end

      assign valid_vec[gi]               = valid_q;
      assign bus.outValid[gi]            = valid_q;
      assign bus.y[gi*size +: size]      = data_q;

`ifdef DEMUX_COUNT_EN
      logic [cntW-1:0] cnt_q;
      logic [cntW-1:0] cnt_d;

      // Pops coinciding with flush are not reported as transfers.
      always_comb begin
        cnt_d = cnt_q;
        if (pop[gi] && !bus.flush) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
`endif
    end
  endgenerate

`ifdef DEMUX_COUNT_EN
  assign bus.count0 = g_ch[0].cnt_q;
  assign bus.count1 = g_ch[1].cnt_q;
`endif

  if (size < 1 || cntW < 1) begin : g_param_check
    $error("demux1x2_buf: size and cntW must be at least 1");
  end

endmodule

// File: tb/tb_demux1x2_buf.sv
// Randomized and directed bench for demux1x2_buf against a slot-level reference model.
module tb_demux1x2_buf;
  localparam int size = 8;
`ifdef DEMUX_COUNT_EN
  localparam int cntW = 2;
`else
  localparam int cntW = 8;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  demux1x2_buf_if #(.size(size), .cntW(cntW)) bus ();

  demux1x2_buf #(.size(size), .cntW(cntW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: each channel is a slot that is either empty or holds one word.
  logic [1:0]      m_valid;
  logic [size-1:0] m_data [2];
  int              m_cnt  [2];
  logic            exp_ready;
  logic [1:0]      m_pop;
  logic [1:0]      m_push;

  always_comb begin
    exp_ready = !bus.flush && (!m_valid[bus.sel] || bus.outReady[bus.sel]);
    m_pop  = '0;
    m_push = '0;
    for (int i = 0; i < 2; i++) begin
      m_pop[i]  = m_valid[i] && bus.outReady[i];
      m_push[i] = bus.inValid && exp_ready && (int'(bus.sel) == i);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= '0;
      m_data[0] <= '0;
      m_data[1] <= '0;
      m_cnt[0]  <= 0;
      m_cnt[1]  <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus.flush)      m_valid[i] <= 1'b0;
        else if (m_push[i]) m_valid[i] <= 1'b1;
        else if (m_pop[i])  m_valid[i] <= 1'b0;
        if (m_push[i]) m_data[i] <= bus.inputVal;
        if (m_pop[i] && !bus.flush) m_cnt[i] <= (m_cnt[i] + 1) % (1 << cntW);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_inReady", 32'(bus.inReady), 32'(exp_ready));
    chk("cyc_outValid", 32'(bus.outValid), 32'(m_valid));
    chk("cyc_y", 32'(bus.y), 32'({m_data[1], m_data[0]}));
`ifdef DEMUX_COUNT_EN
    chk("cyc_count0", 32'(bus.count0), 32'(m_cnt[0]));
    chk("cyc_count1", 32'(bus.count1), 32'(m_cnt[1]));
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.flush    = 1'b0;
    bus.sel      = 1'b0;
    bus.inValid  = 1'b0;
    bus.inputVal = '0;
    bus.outReady = 2'b00;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_outValid", 32'(bus.outValid), 32'h0);
    chk("rst_y", 32'(bus.y), 32'h0);
    chk("rst_inReady", 32'(bus.inReady), 32'h1);
    #10 rst_n = 1'b1;
    cyc();

    // Routing to channel 1
    bus.sel = 1'b1; bus.inputVal = 8'hA5; bus.inValid = 1'b1;
    cyc();
    bus.inValid = 1'b0;
    @(negedge clk);
    chk("route_outValid", 32'(bus.outValid), 32'h2);
    chk("route_y1", 32'(bus.y[15:8]), 32'hA5);
    chk("route_y0", 32'(bus.y[7:0]), 32'h00);

    // Backpressure on channel 1, then switch to channel 0
    cyc();
    bus.sel = 1'b1; bus.inValid = 1'b1; bus.inputVal = 8'h3C;
    @(negedge clk);
    chk("bp_inReady", 32'(bus.inReady), 32'h0);
    cyc();
    @(negedge clk);
    chk("bp_hold_y1", 32'(bus.y[15:8]), 32'hA5);
    chk("bp_inReady2", 32'(bus.inReady), 32'h0);
    cyc();
    bus.sel = 1'b0;
    @(negedge clk);
    chk("bp_switch_ready", 32'(bus.inReady), 32'h1);
    cyc();
    bus.inValid = 1'b0;
    @(negedge clk);
    chk("bp_land_valid", 32'(bus.outValid), 32'h3);
    chk("bp_land_y0", 32'(bus.y[7:0]), 32'h3C);

    // Streaming 1,2,3,4 into channel 0 with consumer ready
    cyc();
    bus.outReady = 2'b01; bus.sel = 1'b0; bus.inValid = 1'b1; bus.inputVal = 8'd1;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin
        cyc();
        bus.inputVal = 8'(k);
      end
      @(negedge clk);
      chk("stream_inReady", 32'(bus.inReady), 32'h1);
      if (k > 1) chk("stream_y0", 32'(bus.y[7:0]), 32'(k - 1));
    end
    cyc();
    bus.inValid = 1'b0; bus.outReady = 2'b00;
    @(negedge clk);
    chk("stream_y0_last", 32'(bus.y[7:0]), 32'h4);
    chk("stream_valid", 32'(bus.outValid), 32'h3);

    // Flush with a word offered
    cyc();
    bus.flush = 1'b1; bus.inValid = 1'b1; bus.sel = 1'b0; bus.inputVal = 8'hFF;
    @(negedge clk);
    chk("flush_inReady", 32'(bus.inReady), 32'h0);
    cyc();
    bus.flush = 1'b0; bus.inValid = 1'b0;
    @(negedge clk);
    chk("flush_outValid", 32'(bus.outValid), 32'h0);
    chk("flush_y", 32'(bus.y), 32'hA504);

    // Asynchronous reset with both channels full
    cyc();
    bus.sel = 1'b0; bus.inValid = 1'b1; bus.inputVal = 8'h5A;
    cyc();
    bus.sel = 1'b1; bus.inputVal = 8'hC3;
    cyc();
    bus.inValid = 1'b0;
    @(negedge clk);
    chk("ar_full", 32'(bus.outValid), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_outValid", 32'(bus.outValid), 32'h0);
    chk("ar_y", 32'(bus.y), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

`ifdef DEMUX_COUNT_EN
    // Counter wrap with cntW=2: five pops on channel 0
    cyc();
    bus.sel = 1'b0; bus.inValid = 1'b1; bus.outReady = 2'b01; bus.inputVal = 8'h77;
    for (int k = 0; k <= 5; k++) begin
      cyc();
      @(negedge clk);
      chk("cnt_count0", 32'(bus.count0), 32'(k % 4));
      chk("cnt_count1", 32'(bus.count1), 32'h0);
    end
    cyc();
    bus.inValid = 1'b0;
`endif

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 600; n++) begin
      cyc();
      bus.sel      = 1'($urandom_range(0, 1));
      bus.inValid  = 1'($urandom_range(0, 3) != 0);
      bus.inputVal = 8'($urandom);
      bus.outReady = 2'($urandom_range(0, 3));
      bus.flush    = 1'($urandom_range(0, 15) == 0);
      if (n == 300) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    cyc();
    bus.inValid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
